ncc_scheduler: RTL and testbench
================================

// Module: ncc_scheduler
// PURPOSE
//  Sequences one NCC match pass: fills the descriptor shift register, fills the 16 per-row window BRAMs,
//  then sweeps window columns into the processing-element array. Tags which sweep cycles produce a valid
//  match score. Sits between the PCI byte stream and the descriptor register / window BRAMs / PE array.
// PARAMETERS
//  DESC_DIM   16  descriptor edge in pixels; DESC_PIXELS = DESC_DIM*DESC_DIM = 256
//  WIN_ROWS   16  window rows, one BRAM each; must equal DESC_DIM
//  WIN_COLS   40  window columns (WIN_ROWS*WIN_COLS = 640 pixels); must be >= DESC_DIM
//  PE_LAT     2   cycles from pe_load_acc to the score at the array output
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    async active-high reset
//  start        in   1                    begin pass; honoured only in IDLE
//  abort        in   1                    synchronous return to IDLE from any state
//  pix_in       in   8                    pixel byte from PCI
//  pix_valid    in   1                    pix_in valid
//  pix_ready    out  1                    byte accepted when pix_valid&&pix_ready
//  desc_load    out  1                    first descriptor byte: load register low byte
//  desc_shift   out  1                    later descriptor bytes: shift 8 then load
//  win_wr       out  1                    window BRAM write strobe
//  win_row      out  $clog2(WIN_ROWS)     BRAM select for write
//  win_addr     out  $clog2(WIN_COLS)     write column address
//  win_rd_en    out  1                    read all row BRAMs
//  win_rd_addr  out  $clog2(WIN_COLS)     read column address, common to all rows
//  pe_load_win  out  1                    load PE window registers (BRAM data valid)
//  pe_load_acc  out  1                    load PE accumulators
//  match_valid  out  1                    one-cycle pulse: array output holds a score
//  match_x      out  $clog2(WIN_COLS)     horizontal offset of that score
//  busy         out  1                    state != IDLE
//  done         out  1                    one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: state IDLE; all counters and the tag pipe cleared; every output 0.
//  States: IDLE -start-> LOAD_DESC -(DESC_PIXELS bytes)-> LOAD_WIN -(WIN_ROWS*WIN_COLS bytes)-> RUN
//   -(col WIN_COLS-1 issued)-> DRAIN -(1+PE_LAT cycles)-> IDLE; done pulses on the DRAIN->IDLE cycle.
//  pix_ready = 1 only in LOAD_DESC and LOAD_WIN. It is combinational on state and drops on the cycle after the last byte.
//  LOAD_DESC: accepted byte k gives desc_load when k==0, else desc_shift. No strobe on non-accepted cycles.
//   Byte counter is $clog2(DESC_PIXELS)+1 bits, so terminal count 256 is representable and does not wrap to 0.
//  LOAD_WIN: raster order, row-major. Byte k gives win_wr=1, win_row=k/WIN_COLS, win_addr=k%WIN_COLS.
//   The column counter wraps at WIN_COLS-1 and increments the row counter.
//  RUN: one column per cycle, no stalls. Cycle c: win_rd_en=1, win_rd_addr=c for c=0..WIN_COLS-1.
//  BRAM read latency 1: pe_load_win and pe_load_acc assert one cycle after each win_rd_en.
//  Tag pipe, depth 1+PE_LAT, carries {valid, col}. match_valid fires 1+PE_LAT cycles after reading col c when
//   c >= DESC_DIM-1, with match_x = c-(DESC_DIM-1). This gives WIN_COLS-DESC_DIM+1 = 25 scores per pass.
//  The tag pipe keeps shifting in DRAIN and flushes in IDLE. Only the pipe drives match_valid.
//  abort: highest priority. It overrides start and in-flight bytes. Next cycle: IDLE, counters cleared,
//   tag pipe cleared (no match_valid after abort), no done pulse. A pix byte presented with abort is not consumed.
//  start while busy: ignored. start and abort in the same IDLE cycle: stay IDLE.
//  pix_valid outside LOAD states: ignored, no strobes.
//  rst mid-pass: immediate return to reset state; outputs 0 asynchronously.
// STRUCTURE
//  ncc_pkg: state enum ncc_sched_state_t {IDLE, LOAD_DESC, LOAD_WIN, RUN, DRAIN}; DESC_DIM, WIN_ROWS, WIN_COLS,
//   PE_LAT defaults; tag struct {logic valid; logic [$clog2(WIN_COLS)-1:0] col;}.
//  Sub-module ncc_wrap_counter #(MAX): enable, clear, count, wrap-pulse. Used for the descriptor byte count,
//   window column/row counts and the RUN/DRAIN counts.
//  FSM, strobe decode and tag pipe live in ncc_scheduler.
// TESTING
//  1 rst held, toggle start/pix_valid -> all outputs 0, busy=0.
//  2 start, 256 bytes with pix_valid=1 ->
//     desc_load on byte 0 only; 255 desc_shift; pix_ready stays 1 into LOAD_WIN.
//  3 640 window bytes with random pix_valid gaps (30%) ->
//     win_wr exactly 640 times; byte 41 gives row 1, addr 1; byte 639 gives row 15, addr 39.
//  4 RUN -> win_rd_addr 0..39 on consecutive cycles;
//     25 match_valid pulses with match_x 0..24, first one 3 cycles after read of col 15;
//     done 3 cycles after col 39; busy falls with done.
//  5 abort at window byte 100 -> next cycle IDLE, pix_ready=0;
//     a new start reloads from descriptor byte 0 (desc_load first).
//  6 abort during RUN at col 20 -> no further match_valid, no done;
//     start in the same cycle as abort is ignored.

Source files
------------

// File: rtl/ncc_pkg.sv
// Shared types and default geometry for the NCC match-pass scheduler.
package ncc_pkg;

  localparam int NCC_DESC_DIM = 16;
  localparam int NCC_WIN_ROWS = 16;
  localparam int NCC_WIN_COLS = 40;
  localparam int NCC_PE_LAT   = 2;

  localparam int NCC_COL_W = $clog2(NCC_WIN_COLS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_DESC = 3'd1,
    LOAD_WIN  = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4
  } ncc_sched_state_t;

  // One entry of the score tag pipe: whether the PE output will hold a
  // score, and which window column was read to produce it.
  typedef struct packed {
    logic                 valid;
    logic [NCC_COL_W-1:0] col;
  } ncc_tag_t;

endpackage

// File: rtl/ncc_scheduler_if.sv
// Control bundle between the scheduler and its surroundings: the PCI byte
// stream, descriptor register strobes, window BRAM ports and PE controls.
interface ncc_scheduler_if
  import ncc_pkg::*;
#(
  parameter int WIN_ROWS = NCC_WIN_ROWS,
  parameter int WIN_COLS = NCC_WIN_COLS
);
  localparam int ROW_W = $clog2(WIN_ROWS);
  localparam int COL_W = $clog2(WIN_COLS);

  logic             start;
  logic             abort;
  logic [7:0]       pix;
  logic             pix_valid;
  logic             pix_ready;
  logic             desc_load;
  logic             desc_shift;
  logic             win_wr;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_addr;
  logic             win_rd_en;
  logic [COL_W-1:0] win_rd_addr;
  logic             pe_load_win;
  logic             pe_load_acc;
  logic             match_valid;
  logic [COL_W-1:0] match_x;
  logic             busy;
  logic             done;

  // Host / datapath side: issues commands and bytes, observes strobes.
  modport master (
    output start, abort, pix, pix_valid,
    input  pix_ready, desc_load, desc_shift, win_wr, win_row, win_addr,
           win_rd_en, win_rd_addr, pe_load_win, pe_load_acc,
           match_valid, match_x, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, abort, pix, pix_valid,
    output pix_ready, desc_load, desc_shift, win_wr, win_row, win_addr,
           win_rd_en, win_rd_addr, pe_load_win, pe_load_acc,
           match_valid, match_x, busy, done
  );

endinterface

// File: rtl/ncc_wrap_counter.sv
// Up-counter 0..MAX with synchronous clear and a wrap pulse on the enabled
// cycle that rolls MAX over to 0. Width can be widened beyond the minimum.
module ncc_wrap_counter #(
  parameter int MAX = 15,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;

  // Clear wins over enable; enabled count rolls over at MAX.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = en_i && !clear_i && (count_q == MAX_V);

endmodule

// File: rtl/ncc_scheduler.sv
// Sequences one NCC match pass: descriptor load, window BRAM fill, then a
// column sweep into the PE array, tagging the sweep cycles that yield scores.
module ncc_scheduler
  import ncc_pkg::*;
#(
  parameter int DESC_DIM = NCC_DESC_DIM,
  parameter int WIN_ROWS = NCC_WIN_ROWS,
  parameter int WIN_COLS = NCC_WIN_COLS,
  parameter int PE_LAT   = NCC_PE_LAT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ncc_scheduler_if.slave  bus
);
  localparam int DESC_PIXELS = DESC_DIM * DESC_DIM;
  localparam int ROW_W       = $clog2(WIN_ROWS);
  localparam int COL_W       = $clog2(WIN_COLS);
  // One spare bit so the terminal descriptor count is representable.
  localparam int DCNT_W      = $clog2(DESC_PIXELS) + 1;
  localparam int DRN_W       = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);
  localparam int PIPE_D      = 1 + PE_LAT;
  localparam int TAG_W       = $bits(ncc_tag_t) - 1;

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_LOAD_DESC = LOAD_DESC;
  localparam logic [2:0] ST_LOAD_WIN  = LOAD_WIN;
  localparam logic [2:0] ST_RUN       = RUN;
  localparam logic [2:0] ST_DRAIN     = DRAIN;

  localparam logic [DCNT_W-1:0] DESC_LAST = DCNT_W'(DESC_PIXELS - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(PE_LAT);
  localparam logic [COL_W-1:0]  FIRST_SCORE_COL = COL_W'(DESC_DIM - 1);

  logic [2:0] state_q, state_d;
  logic       in_idle, in_desc, in_win, in_run, in_drain;
  logic       accept;

  logic [DCNT_W-1:0] desc_cnt;
  logic              desc_wrap;
  logic              desc_last;
  logic [COL_W-1:0]  col_cnt;
  logic              col_wrap;
  logic [ROW_W-1:0]  row_cnt;
  logic              row_wrap;
  logic [COL_W-1:0]  run_cnt;
  logic              run_wrap;
  logic [DRN_W-1:0]  drn_cnt;
  logic              drn_wrap;

  ncc_tag_t tag_in;
  ncc_tag_t tail;
  ncc_tag_t pipe_q [PIPE_D];
  logic     pe_load_q;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_desc  = (state_q == ST_LOAD_DESC);
  assign in_win   = (state_q == ST_LOAD_WIN);
  assign in_run   = (state_q == ST_RUN);
  assign in_drain = (state_q == ST_DRAIN);

  // A byte presented alongside abort is refused rather than half-consumed.
  assign bus.pix_ready = (in_desc || in_win) && !bus.abort;
  assign accept        = bus.pix_valid && bus.pix_ready;

  // Descriptor byte count; cleared whenever we are not loading descriptors.
  ncc_wrap_counter #(.MAX(DESC_PIXELS), .W(DCNT_W)) u_desc_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.abort || !in_desc),
    .en_i    (accept && in_desc),
    .count_o (desc_cnt),
    .wrap_o  (desc_wrap)
  );
  assign desc_last = accept && in_desc && ((desc_cnt == DESC_LAST) || desc_wrap);

  // Window column address within the current row.
  ncc_wrap_counter #(.MAX(WIN_COLS - 1), .W(COL_W)) u_col_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.abort || !in_win),
    .en_i    (accept && in_win),
    .count_o (col_cnt),
    .wrap_o  (col_wrap)
  );

  // Window row (BRAM select); its wrap marks the last window byte.
  ncc_wrap_counter #(.MAX(WIN_ROWS - 1), .W(ROW_W)) u_row_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.abort || !in_win),
    .en_i    (col_wrap),
    .count_o (row_cnt),
    .wrap_o  (row_wrap)
  );

  // Sweep column, one per RUN cycle.
  ncc_wrap_counter #(.MAX(WIN_COLS - 1), .W(COL_W)) u_run_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.abort || !in_run),
    .en_i    (in_run),
    .count_o (run_cnt),
    .wrap_o  (run_wrap)
  );

  // DRAIN length: BRAM read latency plus PE latency.
  ncc_wrap_counter #(.MAX(PE_LAT), .W(DRN_W)) u_drn_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.abort || !in_drain),
    .en_i    (in_drain),
    .count_o (drn_cnt),
    .wrap_o  (drn_wrap)
  );

  // Next-state decode; abort beats every other transition including start.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (bus.start) state_d = ST_LOAD_DESC;
        ST_LOAD_DESC: if (desc_last) state_d = ST_LOAD_WIN;
        ST_LOAD_WIN:  if (row_wrap)  state_d = ST_RUN;
        ST_RUN:       if (run_wrap)  state_d = ST_DRAIN;
        ST_DRAIN:     if (drn_wrap)  state_d = ST_IDLE;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // BRAM data appears one cycle after the read, so PE loads trail win_rd_en.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_load_q <= 1'b0;
    end else begin
      pe_load_q <= in_run && !bus.abort;
    end
  end

  // Columns left of DESC_DIM-1 cannot complete a full descriptor overlap.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = in_run && (run_cnt >= FIRST_SCORE_COL);
    tag_in.col   = TAG_W'(run_cnt);
  end

  // Tag pipe shifts every cycle (flushing zeros when idle); abort empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
    end else if (bus.abort) begin
      for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[PIPE_D-1];

  assign bus.desc_load   = accept && in_desc && (desc_cnt == '0);
  assign bus.desc_shift  = accept && in_desc && (desc_cnt != '0);
  assign bus.win_wr      = accept && in_win;
  assign bus.win_row     = bus.win_wr ? row_cnt : '0;
  assign bus.win_addr    = bus.win_wr ? col_cnt : '0;
  assign bus.win_rd_en   = in_run;
  assign bus.win_rd_addr = in_run ? run_cnt : '0;
  assign bus.pe_load_win = pe_load_q;
  assign bus.pe_load_acc = pe_load_q;
  assign bus.match_valid = tail.valid;
  assign bus.match_x     = tail.valid ? COL_W'(tail.col - TAG_W'(DESC_DIM - 1)) : '0;
  assign bus.busy        = !in_idle;
  assign bus.done        = in_drain && (drn_cnt == DRN_LAST) && !bus.abort;

endmodule

// File: tb/tb_ncc_scheduler.sv
// Self-checking bench for ncc_scheduler: random byte gaps, a high-level
// timing model for the sweep, abort and reset scenarios.
module tb_ncc_scheduler;
  import ncc_pkg::*;

  localparam int DD    = 16;
  localparam int WR    = 16;
  localparam int WC    = 40;
  localparam int LAT   = 3;      // BRAM read + PE latency
  localparam int NDESC = DD * DD;
  localparam int NWIN  = WR * WC;
  localparam int NRUN  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ncc_scheduler_if bus ();

  ncc_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [63:0] all_outs();
    return 64'({bus.pix_ready, bus.desc_load, bus.desc_shift, bus.win_wr, bus.win_row,
                bus.win_addr, bus.win_rd_en, bus.win_rd_addr, bus.pe_load_win,
                bus.pe_load_acc, bus.match_valid, bus.match_x, bus.busy, bus.done});
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.pix_valid = 1'b0; bus.pix = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.pix_valid = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom); bus.pix_valid = 1'($urandom); bus.pix = 8'($urandom);
      bus.abort = 1'b0;
      #1;
      checks++;
      if (all_outs() !== 64'd0) begin
        errors++; $display("FAIL reset_outs cyc=%0d got=%h want=0", i, all_outs());
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, bus.busy);
      end
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL post_reset_idle got=%h want=0", all_outs());
    end
    $display("reset: done, errors=%0d", errors);
  endtask

  task automatic test_desc_load();
    int nload = 0, nshift = 0;
    logic [3:0] got, want;
    @(negedge clk);
    bus.start = 1'b1; bus.pix_valid = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.pix_ready} !== 2'b00) begin
      errors++; $display("FAIL start_idle busy/ready got=%b want=00", {bus.busy, bus.pix_ready});
    end
    for (int k = 0; k < NDESC; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix = 8'($urandom);
      #1;
      want = {1'b1, (k == 0), (k != 0), 1'b0};
      got  = {bus.pix_ready, bus.desc_load, bus.desc_shift, bus.win_wr};
      nload  += int'(bus.desc_load);
      nshift += int'(bus.desc_shift);
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL desc_byte k=%0d rdy/load/shift/wr got=%b want=%b", k, got, want);
      end
    end
    checks++;
    if (nload != 1) begin errors++; $display("FAIL desc_load_count got=%0d want=1", nload); end
    checks++;
    if (nshift != NDESC - 1) begin
      errors++; $display("FAIL desc_shift_count got=%0d want=%0d", nshift, NDESC - 1);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    checks++;
    if ({bus.pix_ready, bus.desc_load, bus.desc_shift} !== 3'b100) begin
      errors++;
      $display("FAIL ready_into_win got=%b want=100", {bus.pix_ready, bus.desc_load, bus.desc_shift});
    end
    $display("desc_load: loads=%0d shifts=%0d", nload, nshift);
  endtask

  task automatic test_win_load();
    int k = 0, cyc = 0, nwr = 0;
    logic v;
    logic [12:0] got, want;
    while (k < NWIN && cyc < 3000) begin
      @(negedge clk);
      v = ($urandom_range(0, 99) >= 30);
      bus.pix_valid = v; bus.pix = 8'($urandom);
      #1;
      nwr += int'(bus.win_wr);
      want = {v, 2'b00, v ? 4'(k / WC) : 4'd0, v ? 6'(k % WC) : 6'd0};
      got  = {bus.win_wr, bus.desc_load, bus.desc_shift,
              v ? bus.win_row : 4'd0, v ? bus.win_addr : 6'd0};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL win_byte k=%0d wr/dl/ds/row/addr got=%h want=%h", k, got, want);
      end
      if (v && (k == 41 || k == NWIN - 1)) begin
        checks++;
        if ({bus.win_row, bus.win_addr} !== ((k == 41) ? {4'd1, 6'd1} : {4'd15, 6'd39})) begin
          errors++;
          $display("FAIL win_corner k=%0d row=%0d addr=%0d", k, bus.win_row, bus.win_addr);
        end
      end
      if (v) k++;
      cyc++;
    end
    checks++;
    if (k != NWIN || nwr != NWIN) begin
      errors++; $display("FAIL win_count accepted=%0d strobes=%0d want=%0d", k, nwr, NWIN);
    end
    $display("win_load: %0d bytes in %0d cycles", k, cyc);
  endtask

  task automatic test_run();
    logic        e_rd [NRUN];
    logic [5:0]  e_ad [NRUN];
    logic        e_pe [NRUN];
    logic        e_mv [NRUN];
    logic [5:0]  e_mx [NRUN];
    logic        e_dn [NRUN];
    logic [19:0] got, want;
    int nmv = 0, first_mv = -1, done_n = -1, busy_fall = -1;
    for (int n = 0; n < NRUN; n++) begin
      e_rd[n] = 0; e_ad[n] = 0; e_pe[n] = 0; e_mv[n] = 0; e_mx[n] = 0; e_dn[n] = 0;
    end
    // Reference: read col c on sweep cycle c; its score emerges LAT cycles later.
    for (int c = 0; c < WC; c++) begin
      e_rd[c] = 1; e_ad[c] = 6'(c); e_pe[c + 1] = 1;
      if (c >= DD - 1) begin e_mv[c + LAT] = 1; e_mx[c + LAT] = 6'(c - (DD - 1)); end
    end
    e_dn[WC - 1 + LAT] = 1;
    for (int n = 0; n < NRUN; n++) begin
      @(negedge clk);
      bus.pix_valid = 1'($urandom);
      #1;
      want = {e_rd[n], e_ad[n], e_pe[n], e_pe[n], e_mv[n], e_mx[n], e_dn[n],
              (n <= WC - 1 + LAT), 2'b00};
      got  = {bus.win_rd_en, e_rd[n] ? bus.win_rd_addr : 6'd0, bus.pe_load_win,
              bus.pe_load_acc, bus.match_valid, e_mv[n] ? bus.match_x : 6'd0, bus.done,
              bus.busy, bus.pix_ready, bus.win_wr};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL run_cycle n=%0d got=%h want=%h", n, got, want);
      end
      if (bus.match_valid === 1'b1) begin nmv++; if (first_mv < 0) first_mv = n; end
      if (bus.done === 1'b1 && done_n < 0) done_n = n;
      if (bus.busy === 1'b0 && busy_fall < 0) busy_fall = n;
    end
    bus.pix_valid = 1'b0;
    checks++;
    if (nmv != WC - DD + 1) begin errors++; $display("FAIL match_count got=%0d want=%0d", nmv, WC - DD + 1); end
    checks++;
    if (first_mv != DD - 1 + LAT) begin
      errors++; $display("FAIL first_match cyc got=%0d want=%0d", first_mv, DD - 1 + LAT);
    end
    checks++;
    if (done_n != WC - 1 + LAT || busy_fall != WC + LAT) begin
      errors++;
      $display("FAIL done_timing done=%0d busy_fall=%0d want=%0d/%0d", done_n, busy_fall,
               WC - 1 + LAT, WC + LAT);
    end
    $display("run: matches=%0d first=%0d done=%0d", nmv, first_mv, done_n);
  endtask

  task automatic test_abort_win();
    pulse_start();
    feed(NDESC + 100);
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.abort = 1'b1;
    #1;
    checks++;
    if ({bus.win_wr, bus.pix_ready} !== 2'b00) begin
      errors++; $display("FAIL abort_byte_consumed wr/ready got=%b want=00", {bus.win_wr, bus.pix_ready});
    end
    @(negedge clk);
    bus.abort = 1'b0; bus.pix_valid = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.pix_ready, bus.win_wr, bus.desc_load} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_win_idle busy/rdy/wr/dl got=%b want=0000",
               {bus.busy, bus.pix_ready, bus.win_wr, bus.desc_load});
    end
    pulse_start();
    feed(1);
    #1;
    checks++;
    if ({bus.desc_load, bus.desc_shift} !== 2'b10) begin
      errors++; $display("FAIL restart_desc_load load/shift got=%b want=10", {bus.desc_load, bus.desc_shift});
    end
    @(negedge clk);
    bus.pix_valid = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_desc_idle busy got=%b want=0", bus.busy); end
    $display("abort_win: done, errors=%0d", errors);
  endtask

  task automatic test_abort_run();
    int stray = 0;
    pulse_start();
    feed(NDESC + NWIN);
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      if (n == 20) begin bus.abort = 1'b1; bus.start = 1'b1; end
      #1;
      checks++;
      if ({bus.win_rd_en, bus.win_rd_addr} !== {1'b1, 6'(n)}) begin
        errors++; $display("FAIL abort_run_col n=%0d got=%0d en=%b", n, bus.win_rd_addr, bus.win_rd_en);
      end
    end
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      bus.abort = 1'b0; bus.start = 1'b0;
      #1;
      if (bus.match_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL after_abort_run stray_cycles got=%0d want=0", stray);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.pix_ready} !== 2'b00) begin
      errors++; $display("FAIL start_with_abort busy/rdy got=%b want=00", {bus.busy, bus.pix_ready});
    end
    $display("abort_run: done, errors=%0d", errors);
  endtask

  task automatic test_async_reset();
    pulse_start();
    feed(NDESC + 10);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 64'd0) begin
      errors++; $display("FAIL async_reset_outs got=%h want=0", all_outs());
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_idle busy got=%b want=0", bus.busy); end
    $display("async_reset: done, errors=%0d", errors);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_desc_load();
    test_win_load();
    test_run();
    test_abort_win();
    test_abort_run();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
